// File: rtl/vga_sync_timer.sv
// Raster timing source: pixel/line counters with sync, display-enable and
// single-cycle line/frame/vblank strobes for the downstream colouring stage.
module vga_sync_timer #(
    parameter int unsigned H_DISPLAY  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_DISPLAY  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter logic        H_SYNC_POL = 1'b0,
    parameter logic        V_SYNC_POL = 1'b0
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_pix_en,
    output logic         o_hsync,
    output logic         o_vsync,
    output logic         o_display_on,
    output logic [9:0]   o_hpos,
    output logic [9:0]   o_vpos,
    output logic         o_line_start,
    output logic         o_frame_start,
    output logic         o_vblank_start,
    output logic [7:0]   o_frame_count
);

    localparam int unsigned CNT_W   = 10;
    localparam int unsigned FC_W    = 8;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_MAX      = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_MAX      = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_DISPLAY);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_DISPLAY);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_DISPLAY + H_FRONT);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_DISPLAY + V_FRONT);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic [CNT_W-1:0] r_hpos;
    logic [CNT_W-1:0] r_vpos;
    logic [FC_W-1:0]  r_frame_count;

    logic w_h_last;
    logic w_v_last;
    logic w_h_visible;
    logic w_v_visible;
    logic w_hs_window;
    logic w_vs_window;
    logic w_strobe_en;
    logic w_at_line_head;

    assign w_h_last = (r_hpos == H_MAX);
    assign w_v_last = (r_vpos == V_MAX);

    // Position counters; everything holds while the pixel enable is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hpos        <= '0;
            r_vpos        <= '0;
            r_frame_count <= '0;
        end else if (i_pix_en) begin
            if (w_h_last) begin
                r_hpos <= '0;
                if (w_v_last) begin
                    r_vpos        <= '0;
                    r_frame_count <= r_frame_count + FC_W'(1);
                end else begin
                    r_vpos <= r_vpos + CNT_W'(1);
                end
            end else begin
                r_hpos <= r_hpos + CNT_W'(1);
            end
        end
    end

    // Zero-latency decode of the registered position.
    assign w_h_visible    = (r_hpos < H_VIS);
    assign w_v_visible    = (r_vpos < V_VIS);
    assign w_hs_window    = (r_hpos >= HS_FIRST) && (r_hpos <= HS_LAST);
    assign w_vs_window    = (r_vpos >= VS_FIRST) && (r_vpos <= VS_LAST);
    assign w_strobe_en    = i_pix_en && !i_reset;
    assign w_at_line_head = (r_hpos == '0);

    // Level outputs are forced inactive while reset is held.
    assign o_hsync        = (w_hs_window && !i_reset) ? H_SYNC_POL : ~H_SYNC_POL;
    assign o_vsync        = (w_vs_window && !i_reset) ? V_SYNC_POL : ~V_SYNC_POL;
    assign o_display_on   = w_h_visible && w_v_visible && !i_reset;

    // Strobes fire only on the enabled cycle, so each position visit yields one pulse.
    assign o_line_start   = w_strobe_en && w_at_line_head;
    assign o_frame_start  = w_strobe_en && w_at_line_head && (r_vpos == '0);
    assign o_vblank_start = w_strobe_en && w_at_line_head && (r_vpos == V_VIS);

    assign o_hpos         = r_hpos;
    assign o_vpos         = r_vpos;
    assign o_frame_count  = r_frame_count;

endmodule

// File: tb/tb_vga_sync_timer.sv
// Bench for vga_sync_timer: a full-size 640x480 instance and a tiny-raster instance
// (inverted hsync polarity) checked every cycle against a linear-pixel-index model.
`timescale 1ns/1ps
module tb_vga_sync_timer;

    // Tiny raster so whole frames and the 8-bit frame wrap fit in a short run.
    localparam int SHD = 10, SHF = 2, SHS = 3, SHB = 3;
    localparam int SVD = 6,  SVF = 2, SVS = 2, SVB = 2;
    localparam int S_HT = SHD + SHF + SHS + SHB;     // 18
    localparam int S_FRAME = S_HT * (SVD + SVF + SVS + SVB); // 216
    localparam int D_FRAME = 800 * 525;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       de;
        logic [9:0] h;
        logic [9:0] v;
        logic       ls;
        logic       fs;
        logic       vbs;
        logic [7:0] fc;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    logic pix_en;

    logic       d_hs, d_vs, d_de, d_ls, d_fs, d_vbs;
    logic [9:0] d_h, d_v;
    logic [7:0] d_fc;
    logic       s_hs, s_vs, s_de, s_ls, s_fs, s_vbs;
    logic [9:0] s_h, s_v;
    logic [7:0] s_fc;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vga_sync_timer u_dut_full (
        .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en),
        .o_hsync(d_hs), .o_vsync(d_vs), .o_display_on(d_de),
        .o_hpos(d_h), .o_vpos(d_v),
        .o_line_start(d_ls), .o_frame_start(d_fs), .o_vblank_start(d_vbs),
        .o_frame_count(d_fc)
    );

    vga_sync_timer #(
        .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
        .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0)
    ) u_dut_small (
        .i_clk(clk), .i_reset(reset), .i_pix_en(pix_en),
        .o_hsync(s_hs), .o_vsync(s_vs), .o_display_on(s_de),
        .o_hpos(s_h), .o_vpos(s_v),
        .o_line_start(s_ls), .o_frame_start(s_fs), .o_vblank_start(s_vbs),
        .o_frame_count(s_fc)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs from a linear pixel index into the frame.
    function automatic obs_t model_out(input int idx, input int fc,
                                       input int hd, input int hf, input int hs, input int hb,
                                       input int vd, input int vf, input int vs,
                                       input bit hp, input bit vp, input bit r, input bit e);
        obs_t o;
        int ht, h, v;
        bit st;
        ht = hd + hf + hs + hb;
        h  = idx % ht;
        v  = idx / ht;
        st = e && !r;
        o.hs  = (h >= hd + hf && h < hd + hf + hs && !r) ? hp : !hp;
        o.vs  = (v >= vd + vf && v < vd + vf + vs && !r) ? vp : !vp;
        o.de  = (h < hd) && (v < vd) && !r;
        o.h   = 10'(h);
        o.v   = 10'(v);
        o.ls  = st && (h == 0);
        o.fs  = st && (h == 0) && (v == 0);
        o.vbs = st && (h == 0) && (v == vd);
        o.fc  = 8'(fc);
        return o;
    endfunction

    task automatic cmp(input string p, input obs_t a, input obs_t e);
        chk({p, ".hsync"},        32'(a.hs),  32'(e.hs));
        chk({p, ".vsync"},        32'(a.vs),  32'(e.vs));
        chk({p, ".display_on"},   32'(a.de),  32'(e.de));
        chk({p, ".hpos"},         32'(a.h),   32'(e.h));
        chk({p, ".vpos"},         32'(a.v),   32'(e.v));
        chk({p, ".line_start"},   32'(a.ls),  32'(e.ls));
        chk({p, ".frame_start"},  32'(a.fs),  32'(e.fs));
        chk({p, ".vblank_start"}, 32'(a.vbs), 32'(e.vbs));
        chk({p, ".frame_count"},  32'(a.fc),  32'(e.fc));
    endtask

    // Model state: pixel index within the frame and completed-frame count.
    int idx_d = 0, fc_d = 0, idx_s = 0, fc_s = 0;
    bit mvalid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            idx_d  <= 0; fc_d <= 0;
            idx_s  <= 0; fc_s <= 0;
            mvalid <= 1'b1;
        end else if (pix_en) begin
            idx_d <= (idx_d + 1 == D_FRAME) ? 0 : idx_d + 1;
            fc_d  <= (idx_d + 1 == D_FRAME) ? (fc_d + 1) % 256 : fc_d;
            idx_s <= (idx_s + 1 == S_FRAME) ? 0 : idx_s + 1;
            fc_s  <= (idx_s + 1 == S_FRAME) ? (fc_s + 1) % 256 : fc_s;
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            cmp("full",  '{d_hs, d_vs, d_de, d_h, d_v, d_ls, d_fs, d_vbs, d_fc},
                model_out(idx_d, fc_d, 640, 16, 96, 48, 480, 10, 2, 1'b0, 1'b0, reset, pix_en));
            cmp("small", '{s_hs, s_vs, s_de, s_h, s_v, s_ls, s_fs, s_vbs, s_fc},
                model_out(idx_s, fc_s, SHD, SHF, SHS, SHB, SVD, SVF, SVS, 1'b1, 1'b0, reset, pix_en));
        end
    end

    // Apply inputs just after a rising edge, return at the following falling edge.
    task automatic drive(input bit r, input bit e);
        @(posedge clk);
        #1;
        reset  = r;
        pix_en = e;
        @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_cnt, hs_first, hs_last, de_cnt, de_last;
        int off_strobes, on_ls;
        int vb_cnt, vb_h, vb_v, vs_cnt, hs_hi, vb_total;
        bit en;

        reset  = 1'b1;
        pix_en = 1'b1;
        repeat (4) drive(1'b1, 1'b1);
        chk("rst.display_on_gated", 32'(d_de), 32'd0);
        chk("rst.hsync_inactive",   32'(d_hs), 32'd1);
        chk("rst.small_hsync_inactive", 32'(s_hs), 32'd0);
        chk("rst.frame_start_gated", 32'(d_fs), 32'd0);

        // First cycle after release: counters at origin with both strobes.
        drive(1'b0, 1'b1);
        chk("first.hpos",        32'(d_h),  32'd0);
        chk("first.vpos",        32'(d_v),  32'd0);
        chk("first.frame_count", 32'(d_fc), 32'd0);
        chk("first.frame_start", 32'(d_fs), 32'd1);
        chk("first.line_start",  32'(d_ls), 32'd1);
        chk("first.small_frame_start", 32'(s_fs), 32'd1);

        // One full line on the 640x480 raster.
        hs_cnt = 0; hs_first = -1; hs_last = -1; de_cnt = 0; de_last = -1;
        for (int i = 0; i < 800; i++) begin
            if (i > 0) drive(1'b0, 1'b1);
            if (d_hs == 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(d_h);
                hs_last = int'(d_h);
            end
            if (d_de) begin
                de_cnt++;
                de_last = int'(d_h);
            end
        end
        chk("line.hsync_low_cycles", 32'(hs_cnt),   32'd96);
        chk("line.hsync_first_hpos", 32'(hs_first), 32'd656);
        chk("line.hsync_last_hpos",  32'(hs_last),  32'd751);
        chk("line.display_cycles",   32'(de_cnt),   32'd640);
        chk("line.display_last_hpos", 32'(de_last), 32'd639);

        drive(1'b0, 1'b1);
        chk("wrap.hpos",       32'(d_h),  32'd0);
        chk("wrap.vpos",       32'(d_v),  32'd1);
        chk("wrap.line_start", 32'(d_ls), 32'd1);
        chk("wrap.frame_start", 32'(d_fs), 32'd0);

        // Mid-frame reset at (300,1).
        repeat (300) drive(1'b0, 1'b1);
        chk("mid.hpos_before", 32'(d_h), 32'd300);
        drive(1'b1, 1'b1);
        chk("mid.display_gated", 32'(d_de), 32'd0);
        chk("mid.hsync_gated",   32'(d_hs), 32'd1);
        chk("mid.small_hsync_gated", 32'(s_hs), 32'd0);
        chk("mid.small_line_start_gated", 32'(s_ls), 32'd0);
        drive(1'b0, 1'b1);
        chk("mid.hpos_after",  32'(d_h),  32'd0);
        chk("mid.vpos_after",  32'(d_v),  32'd0);
        chk("mid.fc_after",    32'(d_fc), 32'd0);
        chk("mid.frame_start", 32'(d_fs), 32'd1);
        chk("mid.small_hpos",  32'(s_h),  32'd0);
        chk("mid.small_vpos",  32'(s_v),  32'd0);

        // Hold, then alternate the enable for 1600 cycles: exactly 800 steps.
        drive(1'b0, 1'b0);
        chk("hold.hpos", 32'(d_h), 32'd1);
        chk("hold.line_start", 32'(d_ls), 32'd0);
        off_strobes = 0; on_ls = 0;
        for (int i = 0; i < 1600; i++) begin
            en = (i % 2 == 0);
            drive(1'b0, en);
            if (!en) off_strobes += int'(d_ls) + int'(d_fs) + int'(d_vbs)
                                  + int'(s_ls) + int'(s_fs) + int'(s_vbs);
            else     on_ls += int'(d_ls);
        end
        chk("toggle.strobes_when_idle", 32'(off_strobes), 32'd0);
        chk("toggle.line_starts",       32'(on_ls),       32'd1);
        drive(1'b0, 1'b0);
        chk("toggle.hpos", 32'(d_h), 32'd1);
        chk("toggle.vpos", 32'(d_v), 32'd1);

        // 256 whole frames on the tiny raster.
        drive(1'b1, 1'b0);
        vb_cnt = 0; vb_h = -1; vb_v = -1; vs_cnt = 0; hs_hi = 0; vb_total = 0;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < S_FRAME; i++) begin
                drive(1'b0, 1'b1);
                if (i == 0 && f == 0)   chk("frames.fc_f0",   32'(s_fc), 32'd0);
                if (i == 0 && f == 1)   chk("frames.fc_f1",   32'(s_fc), 32'd1);
                if (i == 0 && f == 255) chk("frames.fc_f255", 32'(s_fc), 32'd255);
                vb_total += int'(s_vbs);
                if (f == 0) begin
                    if (s_vbs) begin
                        vb_cnt++;
                        vb_h = int'(s_h);
                        vb_v = int'(s_v);
                    end
                    if (s_vs == 1'b0) vs_cnt++;
                    if (s_hs == 1'b1) hs_hi++;
                end
            end
            if (f == 0) begin
                chk("frame0.vblank_count", 32'(vb_cnt), 32'd1);
                chk("frame0.vblank_hpos",  32'(vb_h),   32'd0);
                chk("frame0.vblank_vpos",  32'(vb_v),   32'd6);
                chk("frame0.vsync_low_cycles", 32'(vs_cnt), 32'd36);
                chk("frame0.hsync_high_cycles", 32'(hs_hi), 32'd36);
            end
        end
        chk("frames.vblank_total", 32'(vb_total), 32'd256);
        drive(1'b0, 1'b1);
        chk("frames.fc_wrapped",  32'(s_fc), 32'd0);
        chk("frames.hpos",        32'(s_h),  32'd0);
        chk("frames.vpos",        32'(s_v),  32'd0);
        chk("frames.frame_start", 32'(s_fs), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
